if_fetch_buffer: RTL and testbench

- Instruction-fetch stage that sits directly downstream of the program counter and upstream of decode.
- Takes the current PC, issues a read to the synchronous instruction memory (1-cycle read latency) and captures the returned word.
- Buffers fetched words in a 2-entry skid FIFO so decode stalls never drop an in-flight fetch.
- Drives the IF/ID pipeline register and back-pressures the PC via PC_Hold; handles branch/jump flush by inserting NOPs.

---
 rtl/if_fetch_buffer_pkg.sv | 27 ++
 rtl/if_fetch_buffer_skid_fifo.sv | 58 +++++
 rtl/if_fetch_buffer.sv | 125 ++++++++++++
 tb/tb_if_fetch_buffer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-stage constants and the buffered word type.
// Used by the fetch buffer top and its skid FIFO.
package if_fetch_buffer_pkg;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int SKID_DEPTH = 2;

    localparam logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INCR   = 32'd4;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pcplus4;
    } fetch_word_t;

    function automatic fetch_word_t make_word(
        input logic [DATA_W-1:0] instr,
        input logic [ADDR_W-1:0] pc
    );
        fetch_word_t w;
        w.instr   = instr;
        w.pcplus4 = pc + PC_INCR;
        return w;
    endfunction

endpackage

// File: rtl/if_fetch_buffer_skid_fifo.sv
// Two-entry skid FIFO of {instr, pcplus4} words.
// Absorbs returning fetches while decode is stalled.
module if_fetch_buffer_skid_fifo
    import if_fetch_buffer_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  fetch_word_t din,
    output fetch_word_t dout,
    output logic [1:0]  count
);

    fetch_word_t mem [SKID_DEPTH];
    logic        wr_ptr;
    logic        rd_ptr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage needs no reset; count gates every read.
    always_ff @(posedge Clock) begin
        if (push && !flush)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

    a_no_underflow: assert property (
        @(posedge Clock) disable iff (Reset)
        !(pop && !flush && count == 2'd0));

    a_no_overflow: assert property (
        @(posedge Clock) disable iff (Reset)
        !(push && !pop && !flush && count == 2'd2));

    a_count_range: assert property (
        @(posedge Clock) disable iff (Reset)
        count <= 2'd2);

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction fetch stage: issues PC to sync IMem, skids returns,
// drives the IF/ID register and back-pressures the PC.
module if_fetch_buffer
    import if_fetch_buffer_pkg::*;
(
    input  logic              Clock,
    input  logic              Reset,
    input  logic [ADDR_W-1:0] PC_Addr,
    input  logic              PC_Valid,
    input  logic              ID_Stall,
    input  logic              Flush,
    output logic [ADDR_W-1:0] IMem_Addr,
    output logic              IMem_En,
    input  logic [DATA_W-1:0] IMem_Data,
    output logic              PC_Hold,
    output logic [DATA_W-1:0] IF_ID_Instr,
    output logic [ADDR_W-1:0] IF_ID_PCPlus4,
    output logic              IF_ID_Valid
);

    localparam logic [2:0] HOLD_LVL = 3'(SKID_DEPTH);

    logic              req_valid;
    logic [ADDR_W-1:0] req_pc;
    logic [1:0]        skid_count;
    fetch_word_t       skid_head;
    fetch_word_t       arr_word;
    logic              hold_raw;
    logic              issue;
    logic              arrive;

    logic              skid_push;
    logic              skid_pop;
    logic              load;
    fetch_word_t       next_word;
    logic              next_valid;

    // In-flight request plus buffered words must fit the skid.
    assign hold_raw  = ({1'b0, skid_count} + {2'b00, req_valid})
                       >= HOLD_LVL;
    assign PC_Hold   = hold_raw & ~Reset;
    assign issue     = PC_Valid & ~hold_raw & ~Flush & ~Reset;
    assign IMem_En   = issue;
    assign IMem_Addr = PC_Addr;

    assign arrive    = req_valid & ~Flush;
    assign arr_word  = make_word(IMem_Data, req_pc);

    always_comb begin
        skid_push  = 1'b0;
        skid_pop   = 1'b0;
        load       = 1'b0;
        next_word  = arr_word;
        next_valid = 1'b0;
        priority case (1'b1)
            Flush: begin
                load      = 1'b1;
                next_word = '{instr: NOP_INSTR,
                              pcplus4: IF_ID_PCPlus4};
            end
            ID_Stall: begin
                skid_push = arrive;
            end
            (skid_count != 2'd0): begin
                skid_pop   = 1'b1;
                skid_push  = arrive;
                load       = 1'b1;
                next_word  = skid_head;
                next_valid = 1'b1;
            end
            arrive: begin
                load       = 1'b1;
                next_valid = 1'b1;
            end
            default: begin
                load      = 1'b1;
                next_word = '{instr: NOP_INSTR,
                              pcplus4: IF_ID_PCPlus4};
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else begin
            req_valid <= issue;
            if (issue)
                req_pc <= PC_Addr;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            IF_ID_Instr   <= NOP_INSTR;
            IF_ID_PCPlus4 <= '0;
            IF_ID_Valid   <= 1'b0;
        end else if (load) begin
            IF_ID_Instr   <= next_word.instr;
            IF_ID_PCPlus4 <= next_word.pcplus4;
            IF_ID_Valid   <= next_valid;
        end
    end

    if_fetch_buffer_skid_fifo u_skid (
        .Clock (Clock),
        .Reset (Reset),
        .push  (skid_push),
        .pop   (skid_pop),
        .flush (Flush),
        .din   (arr_word),
        .dout  (skid_head),
        .count (skid_count)
    );

    a_bubble_is_nop: assert property (
        @(posedge Clock) disable iff (Reset)
        !IF_ID_Valid |-> IF_ID_Instr == NOP_INSTR);

    a_skid_bound: assert property (
        @(posedge Clock) disable iff (Reset)
        skid_count <= 2'd2);

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Directed table-driven bench for the fetch buffer.
// Hand-computed vectors plus reset/async corner sequences.
module tb_if_fetch_buffer;

    logic        Clock;
    logic        Reset;
    logic [31:0] PC_Addr;
    logic        PC_Valid;
    logic        ID_Stall;
    logic        Flush;
    logic [31:0] IMem_Addr;
    logic        IMem_En;
    logic [31:0] IMem_Data;
    logic        PC_Hold;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PCPlus4;
    logic        IF_ID_Valid;

    int tests;
    int fails;

    if_fetch_buffer dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .PC_Addr       (PC_Addr),
        .PC_Valid      (PC_Valid),
        .ID_Stall      (ID_Stall),
        .Flush         (Flush),
        .IMem_Addr     (IMem_Addr),
        .IMem_En       (IMem_En),
        .IMem_Data     (IMem_Data),
        .PC_Hold       (PC_Hold),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_PCPlus4 (IF_ID_PCPlus4),
        .IF_ID_Valid   (IF_ID_Valid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        if (a == 32'h4) return 32'h2009_0003;
        return {8'hC0, a[23:0]};
    endfunction

    // Synchronous instruction memory, 1-cycle latency.
    always @(posedge Clock)
        if (IMem_En)
            IMem_Data <= mem_word(IMem_Addr);

    typedef struct {
        logic        pcv;
        logic [31:0] pc;
        logic        stall;
        logic        flush;
        logic        en;
        logic        hold;
        logic        vld;
        logic [31:0] instr;
        logic [31:0] pcp4;
    } vec_t;

    vec_t seq[$];

    function automatic vec_t mk(
        input logic pcv, input logic [31:0] pc,
        input logic stall, input logic flush,
        input logic en, input logic hold,
        input logic vld, input logic [31:0] instr,
        input logic [31:0] pcp4);
        vec_t v;
        v.pcv = pcv; v.pc = pc; v.stall = stall; v.flush = flush;
        v.en = en; v.hold = hold;
        v.vld = vld; v.instr = instr; v.pcp4 = pcp4;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %h expected %h",
                     name, idx, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset    = 1'b1;
        PC_Valid = 1'b1;
        PC_Addr  = 32'h10;
        ID_Stall = 1'b0;
        Flush    = 1'b0;
        @(posedge Clock);
        #1;
        chk("rst_valid", 0, {31'b0, IF_ID_Valid}, 32'd0);
        chk("rst_instr", 0, IF_ID_Instr, 32'h0);
        chk("rst_pcp4", 0, IF_ID_PCPlus4, 32'h0);
        chk("rst_hold", 0, {31'b0, PC_Hold}, 32'd0);
        chk("rst_en", 0, {31'b0, IMem_En}, 32'd0);
        @(negedge Clock);
        Reset    = 1'b0;
        PC_Valid = 1'b0;
    endtask

    task automatic run_seq(input string name);
        for (int i = 0; i < seq.size(); i++) begin
            if (i != 0) @(negedge Clock);
            PC_Valid = seq[i].pcv;
            PC_Addr  = seq[i].pc;
            ID_Stall = seq[i].stall;
            Flush    = seq[i].flush;
            #1;
            chk({name, "_en"}, i, {31'b0, IMem_En}, {31'b0, seq[i].en});
            chk({name, "_hold"}, i, {31'b0, PC_Hold},
                {31'b0, seq[i].hold});
            chk({name, "_addr"}, i, IMem_Addr, seq[i].pc);
            @(posedge Clock);
            #1;
            chk({name, "_vld"}, i, {31'b0, IF_ID_Valid},
                {31'b0, seq[i].vld});
            chk({name, "_instr"}, i, IF_ID_Instr, seq[i].instr);
            chk({name, "_pcp4"}, i, IF_ID_PCPlus4, seq[i].pcp4);
        end
        seq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tests    = 0;
        fails    = 0;
        Reset    = 1'b1;
        PC_Valid = 1'b0;
        PC_Addr  = '0;
        ID_Stall = 1'b0;
        Flush    = 1'b0;
        IMem_Data = 32'hDEAD_BEEF;
        #12;

        // Streaming, stall into full skid, drain, PC_Valid drop.
        do_reset();
        seq.push_back(mk(1, 32'h00, 0, 0, 1, 0, 0, 32'h0, 32'h00));
        seq.push_back(mk(1, 32'h04, 0, 0, 1, 0, 1, 32'h2008_0005, 32'h04));
        seq.push_back(mk(1, 32'h08, 0, 0, 1, 0, 1, 32'h2009_0003, 32'h08));
        seq.push_back(mk(1, 32'h0C, 0, 0, 1, 0, 1, 32'hC000_0008, 32'h0C));
        seq.push_back(mk(1, 32'h10, 1, 0, 1, 0, 1, 32'hC000_0008, 32'h0C));
        seq.push_back(mk(1, 32'h14, 1, 0, 0, 1, 1, 32'hC000_0008, 32'h0C));
        seq.push_back(mk(1, 32'h14, 1, 0, 0, 1, 1, 32'hC000_0008, 32'h0C));
        seq.push_back(mk(1, 32'h14, 0, 0, 0, 1, 1, 32'hC000_000C, 32'h10));
        seq.push_back(mk(1, 32'h14, 0, 0, 1, 0, 1, 32'hC000_0010, 32'h14));
        seq.push_back(mk(1, 32'h18, 0, 0, 1, 0, 1, 32'hC000_0014, 32'h18));
        seq.push_back(mk(0, 32'h1C, 0, 0, 0, 0, 1, 32'hC000_0018, 32'h1C));
        seq.push_back(mk(0, 32'h1C, 0, 0, 0, 0, 0, 32'h0, 32'h1C));
        run_seq("stream");

        // Flush with a full skid under stall, then redirect to 0x40.
        do_reset();
        seq.push_back(mk(1, 32'h00, 0, 0, 1, 0, 0, 32'h0, 32'h00));
        seq.push_back(mk(1, 32'h04, 0, 0, 1, 0, 1, 32'h2008_0005, 32'h04));
        seq.push_back(mk(1, 32'h08, 1, 0, 1, 0, 1, 32'h2008_0005, 32'h04));
        seq.push_back(mk(1, 32'h0C, 1, 0, 0, 1, 1, 32'h2008_0005, 32'h04));
        seq.push_back(mk(1, 32'h40, 1, 1, 0, 1, 0, 32'h0, 32'h04));
        seq.push_back(mk(1, 32'h40, 0, 0, 1, 0, 0, 32'h0, 32'h04));
        seq.push_back(mk(1, 32'h44, 0, 0, 1, 0, 1, 32'hC000_0040, 32'h44));
        seq.push_back(mk(0, 32'h48, 0, 0, 0, 0, 1, 32'hC000_0044, 32'h48));
        seq.push_back(mk(0, 32'h48, 0, 0, 0, 0, 0, 32'h0, 32'h48));
        run_seq("flush");

        // PC_Valid low after reset, then flush dropping an arrival.
        do_reset();
        seq.push_back(mk(0, 32'h00, 0, 0, 0, 0, 0, 32'h0, 32'h00));
        seq.push_back(mk(0, 32'h00, 0, 0, 0, 0, 0, 32'h0, 32'h00));
        seq.push_back(mk(1, 32'h00, 0, 0, 1, 0, 0, 32'h0, 32'h00));
        seq.push_back(mk(1, 32'h04, 0, 0, 1, 0, 1, 32'h2008_0005, 32'h04));
        seq.push_back(mk(0, 32'h08, 0, 0, 0, 0, 1, 32'h2009_0003, 32'h08));
        seq.push_back(mk(1, 32'h20, 0, 0, 1, 0, 0, 32'h0, 32'h08));
        seq.push_back(mk(1, 32'h24, 0, 1, 0, 0, 0, 32'h0, 32'h08));
        seq.push_back(mk(1, 32'h80, 0, 0, 1, 0, 0, 32'h0, 32'h08));
        seq.push_back(mk(0, 32'h84, 0, 0, 0, 0, 1, 32'hC000_0080, 32'h84));
        run_seq("pcvalid");

        // PC+4 wrap at the top of the address space.
        do_reset();
        seq.push_back(mk(1, 32'hFFFF_FFFC, 0, 0, 1, 0, 0, 32'h0, 32'h0));
        seq.push_back(mk(0, 32'h0000_0000, 0, 0, 0, 0, 1,
                         32'hC0FF_FFFC, 32'h0));
        seq.push_back(mk(0, 32'h0000_0000, 0, 0, 0, 0, 0, 32'h0, 32'h0));
        run_seq("wrap");

        // Async reset mid-stream with a request in flight.
        do_reset();
        seq.push_back(mk(1, 32'h00, 0, 0, 1, 0, 0, 32'h0, 32'h00));
        seq.push_back(mk(1, 32'h04, 0, 0, 1, 0, 1, 32'h2008_0005, 32'h04));
        run_seq("pre_arst");
        #2;
        Reset = 1'b1;
        #1;
        chk("arst_valid", 0, {31'b0, IF_ID_Valid}, 32'd0);
        chk("arst_instr", 0, IF_ID_Instr, 32'h0);
        chk("arst_pcp4", 0, IF_ID_PCPlus4, 32'h0);
        chk("arst_en", 0, {31'b0, IMem_En}, 32'd0);
        chk("arst_hold", 0, {31'b0, PC_Hold}, 32'd0);
        @(negedge Clock);
        Reset    = 1'b0;
        PC_Valid = 1'b0;
        @(posedge Clock);
        #1;
        chk("arst_stale_vld", 0, {31'b0, IF_ID_Valid}, 32'd0);
        chk("arst_stale_instr", 0, IF_ID_Instr, 32'h0);
        @(posedge Clock);
        #1;
        chk("arst_stale_vld", 1, {31'b0, IF_ID_Valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
